// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the LC-3 operate-instruction issue controller.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    // True for the operate opcodes this block executes.
    function automatic logic is_supported(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// Register file: one synchronous write port, two async operand read ports
// and an async debug read port. Cleared by synchronous reset.
module reg_file_8x16 #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next register contents: hold, or overwrite the addressed entry.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register the array; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1   = regs_q[raddr1];
    assign rdata2   = regs_q[raddr2];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for LC-3 ADD/AND/NOT: decodes the instruction, fetches
// operands for the external ALU, captures its result and writes back DR/NZP.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       IR,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        aluk,
    input  logic [DATA_W-1:0] alu_dout,
    output logic [2:0]        nzp,
    output logic              done,
    output logic              illegal,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int RA_W = $clog2(NREG);

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        aluk_q, aluk_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        nzp_q, nzp_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic              rf_we;
    logic [DATA_W-1:0] sr1_val, sr2_val;

    // Sign-extend the 5-bit immediate to the datapath width.
    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
        return {{(DATA_W-5){imm[4]}}, imm};
    endfunction

    // Condition codes for a writeback value.
    function automatic logic [2:0] calc_nzp(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1])   return NZP_N;
        else if (v == '0)  return NZP_Z;
        else               return NZP_P;
    endfunction

    reg_file_8x16 #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk      (Clk),
        .rst      (Reset),
        .we       (rf_we),
        .waddr    (RA_W'(ir_q[11:9])),
        .wdata    (result_q),
        .raddr1   (RA_W'(ir_q[8:6])),
        .rdata1   (sr1_val),
        .raddr2   (RA_W'(ir_q[2:0])),
        .rdata2   (sr2_val),
        .dbg_addr (RA_W'(dbg_sel)),
        .dbg_data (dbg_data)
    );

    // Writeback happens in the WB state; operands are read in DECODE, so a
    // following instruction's DECODE always sees this write.
    assign rf_we = (state_q == WB);

    // FSM next-state, decode, operand fetch, result capture and NZP update.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        aluk_d    = aluk_q;
        result_d  = result_q;
        nzp_d     = nzp_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    ir_d      = IR;
                    // Flag unsupported opcodes so the pulse lands in DECODE.
                    illegal_d = !is_supported(IR[15:12]);
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (is_supported(ir_q[15:12])) begin
                    alu_a_d = sr1_val;
                    alu_b_d = ir_q[5] ? sext5(ir_q[4:0]) : sr2_val;
                    case (ir_q[15:12])
                        OP_ADD:  aluk_d = ALUK_ADD;
                        OP_AND:  aluk_d = ALUK_AND;
                        default: begin
                            aluk_d  = ALUK_NOT;
                            alu_b_d = '0;
                        end
                    endcase
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                result_d = alu_dout;
                done_d   = 1'b1;
                state_d  = WB;
            end
            WB: begin
                nzp_d   = calc_nzp(result_q);
                aluk_d  = ALUK_PASSA;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any instruction in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            aluk_q    <= ALUK_PASSA;
            result_q  <= '0;
            nzp_q     <= NZP_Z;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            aluk_q    <= aluk_d;
            result_q  <= result_d;
            nzp_q     <= nzp_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign aluk        = aluk_q;
    assign nzp         = nzp_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule
